// File: rtl/knight_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : knight_scan_sequencer_if
//  Purpose  : Request/response bundle between the knight scan sequencer and
//             the square-lookup datapath.
//  Signals  : scan_req/scan_pos/scan_dir -- request (sequencer -> datapath)
//             scan_ok/scan_sq/scan_piece -- response, one cycle after request
//  Revision : 1.0  initial release
// ============================================================================
interface knight_scan_sequencer_if;
  logic       scan_req;
  logic [5:0] scan_pos;
  logic [2:0] scan_dir;
  logic       scan_ok;
  logic [5:0] scan_sq;
  logic [3:0] scan_piece;

  modport master (
    output scan_req, scan_pos, scan_dir,
    input  scan_ok, scan_sq, scan_piece
  );

  modport slave (
    input  scan_req, scan_pos, scan_dir,
    output scan_ok, scan_sq, scan_piece
  );
endinterface
`default_nettype wire

// File: rtl/knight_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : knight_scan_sequencer
//  Purpose  : Walks the 8 knight directions from an origin square, issues one
//             lookup per direction to the scan datapath and accumulates the
//             legal-destination and capture masks from the responses.
//  Ports    : clk, rst_n (async, active low)
//             start/abort       -- scan control
//             bigBoard          -- 64 x 4-bit squares, [3] colour, [2:0] type
//             currentPosition   -- origin square
//             scan              -- datapath request/response (master side)
//             busy/done         -- status, done is a one-cycle pulse
//             move_mask/capture_mask/move_count -- results
//  Revision : 1.0  initial release
// ============================================================================
module knight_scan_sequencer (
  input  wire                       clk,
  input  wire                       rst_n,
  input  wire                       start,
  input  wire                       abort,
  input  wire [255:0]               bigBoard,
  input  wire [5:0]                 currentPosition,
  knight_scan_sequencer_if.master   scan,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               move_mask,
  output logic [63:0]               capture_mask,
  output logic [3:0]                move_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        colour_q, colour_d;
  logic [2:0]  dir_q, dir_d;
  logic        pend_q, pend_d;      // a response from last cycle's request is due now
  logic [63:0] move_q, move_d;
  logic [63:0] cap_q, cap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      colour_q <= 1'b0;
      dir_q    <= '0;
      pend_q   <= 1'b0;
      move_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      colour_q <= colour_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      move_q   <= move_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    colour_d = colour_q;
    dir_d    = dir_q;
    pend_d   = 1'b0;
    move_d   = move_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;

    // An empty or opponent-occupied on-board target is a legal destination.
    legal = scan.scan_ok &&
            ((scan.scan_piece == 4'h0) || (scan.scan_piece[3] != colour_q));

    if (pend_q && legal) begin
      move_d[scan.scan_sq] = 1'b1;
      if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
      if (scan.scan_piece != 4'h0) cap_d[scan.scan_sq] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          pos_d    = currentPosition;
          // An empty origin reads as 4'b0000, so its colour bit is already 0.
          colour_d = bigBoard[{currentPosition, 2'b11}];
          dir_d    = '0;
          move_d   = '0;
          cap_d    = '0;
          cnt_d    = '0;
        end
      end
      SCAN: begin
        pend_d = 1'b1;
        // dir stays at 7 on exit so scan_dir keeps showing the last request.
        if (dir_q == 3'd7) state_d = DRAIN;
        else               dir_d   = dir_q + 3'd1;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      move_d  = '0;
      cap_d   = '0;
      cnt_d   = '0;
    end
  end

  assign scan.scan_req  = (state_q == SCAN);
  assign scan.scan_pos  = pos_q;
  assign scan.scan_dir  = dir_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign move_mask      = move_q;
  assign capture_mask   = cap_q;
  assign move_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_knight_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_knight_scan_sequencer
//  Purpose  : Self-checking bench for knight_scan_sequencer: directed table,
//             randomized boards against a reference model, and hand-written
//             abort / restart / reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_knight_scan_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [255:0] bigBoard;
  logic [5:0]   currentPosition;
  logic         busy;
  logic         done;
  logic [63:0]  move_mask;
  logic [63:0]  capture_mask;
  logic [3:0]   move_count;

  logic [255:0] resp_board;   // board the datapath model looks squares up in
  int           n_cmp;
  int           n_err;

  knight_scan_sequencer_if ifc ();

  knight_scan_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .bigBoard        (bigBoard),
    .currentPosition (currentPosition),
    .scan            (ifc),
    .busy            (busy),
    .done            (done),
    .move_mask       (move_mask),
    .capture_mask    (capture_mask),
    .move_count      (move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Knight offsets per direction code 0..7 (row delta, column delta).
  function automatic int off_r(input logic [2:0] d);
    case (d)
      3'd0: return -1; 3'd1: return -2; 3'd2: return -2; 3'd3: return -1;
      3'd4: return  1; 3'd5: return  2; 3'd6: return  2; default: return 1;
    endcase
  endfunction

  function automatic int off_c(input logic [2:0] d);
    case (d)
      3'd0: return -2; 3'd1: return -1; 3'd2: return  1; 3'd3: return  2;
      3'd4: return  2; 3'd5: return  1; 3'd6: return -1; default: return -2;
    endcase
  endfunction

  function automatic logic tgt_ok(input logic [5:0] p, input logic [2:0] d);
    int r;
    int c;
    r = int'(p) / 8 + off_r(d);
    c = int'(p) % 8 + off_c(d);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  function automatic logic [5:0] tgt_sq(input logic [5:0] p, input logic [2:0] d);
    int r;
    int c;
    r = int'(p) / 8 + off_r(d);
    c = int'(p) % 8 + off_c(d);
    if (tgt_ok(p, d)) return 6'(r * 8 + c);
    return 6'd0;
  endfunction

  // Datapath model: registered one-cycle lookup of the requested target.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.scan_ok    <= 1'b0;
      ifc.scan_sq    <= 6'd0;
      ifc.scan_piece <= 4'h0;
    end else if (ifc.scan_req) begin
      ifc.scan_ok    <= tgt_ok(ifc.scan_pos, ifc.scan_dir);
      ifc.scan_sq    <= tgt_sq(ifc.scan_pos, ifc.scan_dir);
      ifc.scan_piece <= tgt_ok(ifc.scan_pos, ifc.scan_dir) ?
                        resp_board[{tgt_sq(ifc.scan_pos, ifc.scan_dir), 2'b00} +: 4] : 4'h0;
    end else begin
      ifc.scan_ok    <= 1'b0;
      ifc.scan_sq    <= 6'd0;
      ifc.scan_piece <= 4'h0;
    end
  end

  // Reference: every on-board knight target that is empty or holds the
  // opponent's colour is a move; occupied ones are also captures.
  function automatic void model(input logic [255:0] b, input logic [5:0] p,
                                output logic [63:0] mv, output logic [63:0] cp,
                                output logic [3:0] cnt);
    logic       own;
    logic [3:0] pc;
    logic [5:0] t;
    own = b[4 * int'(p) + 3];
    mv  = '0;
    cp  = '0;
    cnt = '0;
    for (int d = 0; d < 8; d++) begin
      if (tgt_ok(p, 3'(d))) begin
        t  = tgt_sq(p, 3'(d));
        pc = b[4 * int'(t) +: 4];
        if (pc == 4'h0 || pc[3] != own) begin
          mv[t] = 1'b1;
          cnt   = cnt + 4'd1;
          if (pc != 4'h0) cp[t] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    b = '0;
    for (int s = 0; s < 64; s++)
      if ($urandom_range(1, 0) == 1) b[4 * s +: 4] = 4'($urandom_range(15, 1));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},     64'(busy), 64'd0);
    chk({tag, " done"},     64'(done), 64'd0);
    chk({tag, " scan_req"}, 64'(ifc.scan_req), 64'd0);
    chk({tag, " scan_pos"}, 64'(ifc.scan_pos), 64'd0);
    chk({tag, " scan_dir"}, 64'(ifc.scan_dir), 64'd0);
    chk({tag, " move"},     move_mask, 64'd0);
    chk({tag, " cap"},      capture_mask, 64'd0);
    chk({tag, " cnt"},      64'(move_count), 64'd0);
  endtask

  // Issue start; returns at the falling edge in the first SCAN cycle with the
  // DUT-side board/position scrambled so only latched values can be used.
  task automatic kick(input logic [255:0] b, input logic [5:0] p);
    @(negedge clk);
    bigBoard        = b;
    currentPosition = p;
    resp_board      = b;
    start           = 1'b1;
    @(negedge clk);
    start           = 1'b0;
    bigBoard        = rand_board();
    currentPosition = 6'($urandom_range(63, 0));
  endtask

  // Counts cycles (1 = first SCAN cycle) until done; restart_k > 0 re-pulses
  // start during cycle restart_k+1.
  task automatic wait_done(input int restart_k, output int dc, output int rc);
    dc = -1;
    rc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (ifc.scan_req) rc++;
      if (done) begin
        dc = k;
        break;
      end
      start = (k == restart_k);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic quiet_done(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, " stray done"}, 64'(extra), 64'd0);
  endtask

  task automatic run_vec(input string tag, input logic [255:0] b, input logic [5:0] p,
                         input logic [63:0] mv, input logic [63:0] cp,
                         input logic [3:0] cnt, input int restart_k);
    int dc;
    int rc;
    kick(b, p);
    wait_done(restart_k, dc, rc);
    chk({tag, " latency"}, 64'(dc), 64'd10);
    chk({tag, " req cycles"}, 64'(rc), 64'd8);
    chk({tag, " move"}, move_mask, mv);
    chk({tag, " cap"}, capture_mask, cp);
    chk({tag, " cnt"}, 64'(move_count), 64'(cnt));
    @(negedge clk);
    chk({tag, " hold move"}, move_mask, mv);
    chk({tag, " idle req"}, 64'(ifc.scan_req), 64'd0);
    quiet_done(tag, 12);
  endtask

  typedef struct {
    logic [255:0] board;
    logic [5:0]   pos;
    logic [63:0]  mv;
    logic [63:0]  cp;
    logic [3:0]   cnt;
  } vec_t;

  vec_t         vecs[5];
  logic [255:0] b;
  logic [63:0]  emv;
  logic [63:0]  ecp;
  logic [3:0]   ecnt;
  logic [5:0]   p;

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    bigBoard        = '0;
    currentPosition = '0;
    resp_board      = '0;

    // Directed vectors with hand-derived expectations.
    b = '0; b[4*0 +: 4] = 4'b0001;
    vecs[0] = '{b, 6'd0, (64'd1 << 10) | (64'd1 << 17), 64'd0, 4'd2};
    b = '0; b[4*27 +: 4] = 4'b0001;
    vecs[1] = '{b, 6'd27,
                (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 21) |
                (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44),
                64'd0, 4'd8};
    b[4*10 +: 4] = 4'b0010; b[4*44 +: 4] = 4'b1011;
    vecs[2] = '{b, 6'd27,
                (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 21) |
                (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44),
                64'd1 << 44, 4'd7};
    b = '0; b[4*63 +: 4] = 4'b1010; b[4*53 +: 4] = 4'b0011; b[4*46 +: 4] = 4'b1100;
    vecs[3] = '{b, 6'd63, 64'd1 << 53, 64'd1 << 53, 4'd1};
    b = '0; b[4*10 +: 4] = 4'b1101;
    vecs[4] = '{b, 6'd0, (64'd1 << 10) | (64'd1 << 17), 64'd1 << 10, 4'd2};

    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].board, vecs[i].pos,
              vecs[i].mv, vecs[i].cp, vecs[i].cnt, 0);

    // Start + abort together in IDLE: abort wins and clears held results.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", 64'(busy), 64'd0);
    chk("start+abort move", move_mask, 64'd0);

    // Abort in the 4th SCAN cycle; dirs 0 and 1 are already captured then.
    kick(vecs[1].board, 6'd27);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre-abort move", move_mask, (64'd1 << 10) | (64'd1 << 17));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort move", move_mask, 64'd0);
    chk("abort cnt", 64'(move_count), 64'd0);
    chk("abort req", 64'(ifc.scan_req), 64'd0);
    quiet_done("abort", 12);
    run_vec("post-abort", vecs[2].board, 6'd27, vecs[2].mv, vecs[2].cp, vecs[2].cnt, 0);

    // Start re-pulsed mid-scan must not disturb the scan or add a done.
    run_vec("restart", vecs[1].board, 6'd27, vecs[1].mv, vecs[1].cp, vecs[1].cnt, 3);

    // Reset mid-scan: outputs clear before any clock edge.
    kick(vecs[1].board, 6'd27);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk);
    chk("reset no done", 64'(done), 64'd0);
    bigBoard        = vecs[0].board;
    currentPosition = 6'd0;
    resp_board      = vecs[0].board;
    start           = 1'b1;
    rst_n           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start after reset", 64'(busy), 64'd1);
    begin
      int dc;
      int rc;
      wait_done(0, dc, rc);
      chk("post-reset latency", 64'(dc), 64'd10);
      chk("post-reset move", move_mask, vecs[0].mv);
    end
    @(negedge clk);

    // Randomized boards against the reference model.
    for (int i = 0; i < 30; i++) begin
      b = rand_board();
      p = 6'($urandom_range(63, 0));
      model(b, p, emv, ecp, ecnt);
      run_vec($sformatf("rand%0d", i), b, p, emv, ecp, ecnt, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/knight_scan_sequencer.md
KNIGHT_SCAN_SEQUENCER -- requirements
Module: knight_scan_sequencer

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-002 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-003 start  in  1  SHALL request one 8-direction knight scan; sampled only in IDLE.
REQ-004 abort  in  1  SHALL cancel any scan in progress.
REQ-005 bigBoard  in  256  SHALL be the board, with square s in bits [4s+3:4s]; bit 3 is colour (1 = black), [2:0] is piece type, and 4'b0000 means empty.
REQ-006 currentPosition  in  6  SHALL be the origin square (row = pos/8, col = pos%8, "up" = row-1).
REQ-007 scan_pos  out  6  SHALL be the origin square driven to the scan datapath.
REQ-008 scan_dir  out  3  SHALL be the direction driven to the scan datapath, encoded 0..7 = UPLEFTLEFT, UPUPLEFT, UPUPRIGHT, UPRIGHTRIGHT, RIGHTRIGHTDOWN, RIGHTDOWNDOWN, LEFTDOWNDOWN, LEFTLEFTDOWN.
REQ-009 scan_req  out  1  SHALL be high while scan_pos/scan_dir carry a live request.
REQ-010 scan_ok  in  1  SHALL indicate that the target square is on the board, one cycle after the request.
REQ-011 scan_sq  in  6  SHALL be the target square, one cycle after the request.
REQ-012 scan_piece  in  4  SHALL be the contents of the target square, one cycle after the request.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.
REQ-014 done  out  1  SHALL be a one-cycle pulse when results are final.
REQ-015 move_mask  out  64  SHALL have bit s set when s is a legal knight destination.
REQ-016 capture_mask  out  64  SHALL be the subset of move_mask holding an opponent piece.
REQ-017 move_count  out  4  SHALL be the popcount of move_mask, 0..8.

Function
REQ-018 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-019 When in IDLE with start=1 and abort=0 at an edge, the block SHALL latch currentPosition into pos_q and own_colour = bigBoard[4*pos+3], clear move_mask, capture_mask and move_count, set dir_cnt=0, and enter SCAN.
REQ-020 In SCAN, the block SHALL drive scan_req=1, scan_pos=pos_q and scan_dir=dir_cnt, and SHALL increment dir_cnt at each edge.
REQ-021 When dir_cnt=7 at an edge, the block SHALL enter DRAIN.
REQ-022 Capture pipeline: the response to the request issued in cycle c SHALL be sampled at the end of cycle c+1, so dir 0 is sampled at the second edge after start and dir 7 at the DRAIN exit edge.
REQ-023 The capture edge SHALL be ignored for the first SCAN cycle, since no response is pending yet.
REQ-024 A sampled response SHALL be legal iff scan_ok=1 and (scan_piece==0 or scan_piece[3]!=own_colour).
REQ-025 On a legal response, the block SHALL set move_mask[scan_sq] and increment move_count (saturating at 8).
REQ-026 On a legal response with scan_piece!=0, the block SHALL also set capture_mask[scan_sq].
REQ-027 DRAIN SHALL last exactly one cycle with scan_req=0, then go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-029 Latency: done SHALL be high in the 10th cycle after the start-sampling edge, with exactly 8 scan_req cycles per scan.
REQ-030 The result outputs SHALL hold their values from DONE until the next accepted start or an abort.
REQ-031 Whenever abort=1 at an edge in any state, the block SHALL go to IDLE, clear all masks and the count, and not pulse done.
REQ-032 When start and abort are both high in IDLE, abort SHALL win and no scan starts.
REQ-033 start SHALL be ignored when busy=1.
REQ-034 Changes to bigBoard or currentPosition during a scan SHALL not affect pos_q or own_colour.
REQ-035 If the origin square is empty, own_colour SHALL be taken as 0.
REQ-036 Outside SCAN, scan_pos and scan_dir SHALL hold their last values and scan_req SHALL be 0.

Reset
REQ-037 While rst_n=0, the block SHALL force state=IDLE, dir_cnt=0, pos_q=0, own_colour=0, and drive busy=0, done=0, scan_req=0, scan_dir=0, scan_pos=0, move_mask=0, capture_mask=0, move_count=0, all asynchronously.
REQ-038 Reset asserted mid-scan SHALL abandon the scan with no done pulse.
REQ-039 After release, the first accepted start SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-040 Empty board, white knight at pos 0, scan model correct -> done at cycle 10, move_mask bits {10,17}, count 2, capture_mask=0.
REQ-041 Empty board, knight at pos 27 -> move_mask bits {10,12,17,21,33,37,42,44}, count 8.
REQ-042 White knight at pos 27, white piece at 10, black piece 4'b1011 at 44 -> bit 10 clear, bit 44 set in both masks, count 7.
REQ-043 Abort asserted in the 4th SCAN cycle -> next cycle IDLE, masks 0, no done pulse; a following start completes normally.
REQ-044 Start pulsed again during SCAN, and rst_n dropped mid-scan in a second run -> the first scan is unaffected, exactly one done; after reset all outputs are 0 immediately.
